// File: rtl/cn_minsum_serial.sv
// rtl/cn_minsum_serial.sv - serial offset min-sum check-node unit with double-banked row storage
module cn_minsum_serial #(
  parameter int MSG_WIDTH  = 6,
  parameter int ROW_WEIGHT = 6,
  parameter int OFFSET     = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [MSG_WIDTH-1:0] i_v2c,
  input  logic                 i_v2c_valid,
  output logic                 o_v2c_ready,
  output logic [MSG_WIDTH-1:0] o_c2v,
  output logic                 o_c2v_valid,
  input  logic                 i_c2v_ready,
  output logic                 o_c2v_last,
  output logic                 o_sign_prod
);

  localparam int MAG_W = MSG_WIDTH - 1;
  localparam int CNT_W = (ROW_WEIGHT > 1) ? $clog2(ROW_WEIGHT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROW_WEIGHT - 1);
  localparam logic [MAG_W-1:0] MAG_MAX  = '1;
  localparam logic [MAG_W-1:0] OFF_M    = MAG_W'(OFFSET);

  typedef enum logic {ACC, FULL} acc_state_t;
  typedef enum logic {IDLE, EMIT} out_state_t;

  acc_state_t acc_state, acc_next;
  out_state_t out_state, out_next;

  // accumulating row
  logic [CNT_W-1:0]      in_cnt;
  logic [MAG_W-1:0]      min1, min2;
  logic [CNT_W-1:0]      idx;
  logic                  sp;
  logic [ROW_WEIGHT-1:0] sign_vec;

  // out bank
  logic [CNT_W-1:0]      out_cnt;
  logic [MAG_W-1:0]      ob_min1, ob_min2;
  logic [CNT_W-1:0]      ob_idx;
  logic                  ob_sp;
  logic [ROW_WEIGHT-1:0] ob_sign_vec;

  logic                  in_sign;
  logic [MAG_W-1:0]      in_mag;
  logic                  v2c_fire, c2v_fire, in_last, out_last, bank_free, xfer;
  logic [MAG_W-1:0]      sel_mag, c2v_mag;
  logic                  c2v_sign;

  assign in_sign   = i_v2c[MSG_WIDTH-1];
  assign in_mag    = i_v2c[MAG_W-1:0];
  assign v2c_fire  = i_v2c_valid && o_v2c_ready;
  assign c2v_fire  = o_c2v_valid && i_c2v_ready;
  assign in_last   = (in_cnt == LAST_CNT);
  assign out_last  = (out_cnt == LAST_CNT);
  // The bank is reusable in the same cycle it hands over its final beat.
  assign bank_free = (out_state == IDLE) || (c2v_fire && out_last);
  assign xfer      = (acc_state == FULL) && bank_free;

  // State registers for both FSMs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_state <= ACC;
      out_state <= IDLE;
    end else begin
      acc_state <= acc_next;
      out_state <= out_next;
    end
  end

  // Accumulator next state and input handshake
  always_comb begin
    acc_next    = acc_state;
    o_v2c_ready = 1'b0;
    case (acc_state)
      ACC: begin
        o_v2c_ready = !i_rst;
        if (v2c_fire && in_last) acc_next = FULL;
      end
      FULL: begin
        if (bank_free) acc_next = ACC;
      end
      default: acc_next = ACC;
    endcase
  end

  // Out bank next state; a transfer arriving on the last beat restarts emission
  always_comb begin
    out_next = out_state;
    case (out_state)
      IDLE: if (xfer) out_next = EMIT;
      EMIT: if (c2v_fire && out_last) out_next = xfer ? EMIT : IDLE;
      default: out_next = IDLE;
    endcase
  end

  // Running min1/min2/idx/sign tracking over the incoming row
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_cnt   <= '0;
      min1     <= '0;
      min2     <= '0;
      idx      <= '0;
      sp       <= 1'b0;
      sign_vec <= '0;
    end else if (v2c_fire) begin
      sign_vec[in_cnt] <= in_sign;
      in_cnt           <= in_last ? '0 : in_cnt + 1'b1;
      if (in_cnt == '0) begin
        min1 <= in_mag;
        min2 <= MAG_MAX;
        idx  <= '0;
        sp   <= in_sign;
      end else begin
        sp <= sp ^ in_sign;
        if (in_mag < min1) begin
          min2 <= min1;
          min1 <= in_mag;
          idx  <= in_cnt;
        end else if (in_mag < min2) begin
          min2 <= in_mag;
        end
      end
    end
  end

  // Out bank load on transfer and beat counter on each consumed beat
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_cnt     <= '0;
      ob_min1     <= '0;
      ob_min2     <= '0;
      ob_idx      <= '0;
      ob_sp       <= 1'b0;
      ob_sign_vec <= '0;
    end else if (xfer) begin
      out_cnt     <= '0;
      ob_min1     <= min1;
      ob_min2     <= min2;
      ob_idx      <= idx;
      ob_sp       <= sp;
      ob_sign_vec <= sign_vec;
    end else if (c2v_fire) begin
      out_cnt <= out_last ? '0 : out_cnt + 1'b1;
    end
  end

  // c2v message: exclude-self minimum minus offset, zero magnitude never carries a sign
  always_comb begin
    sel_mag     = (out_cnt == ob_idx) ? ob_min2 : ob_min1;
    c2v_mag     = (sel_mag > OFF_M) ? sel_mag - OFF_M : '0;
    c2v_sign    = (c2v_mag != '0) && (ob_sp ^ ob_sign_vec[out_cnt]);
    o_c2v_valid = (out_state == EMIT) && !i_rst;
    o_c2v       = o_c2v_valid ? {c2v_sign, c2v_mag} : '0;
    o_c2v_last  = o_c2v_valid && out_last;
    o_sign_prod = o_c2v_valid && ob_sp;
  end

endmodule

// File: tb/tb_cn_minsum_serial.sv
// tb/tb_cn_minsum_serial.sv - scoreboard bench for cn_minsum_serial
module tb_cn_minsum_serial;

  localparam int MW  = 6;
  localparam int RW  = 6;
  localparam int OFF = 1;

  typedef logic [MW-2:0] mag_arr_t [RW];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MW-1:0] v2c = '0;
  logic          v2c_valid = 1'b0;
  logic          v2c_ready;
  logic [MW-1:0] c2v;
  logic          c2v_valid;
  logic          c2v_ready = 1'b1;
  logic          c2v_last;
  logic          sign_prod;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [MW+1:0] sb [$];
  logic          stall_prev = 1'b0;
  logic [MW+1:0] held = '0;

  cn_minsum_serial #(.MSG_WIDTH(MW), .ROW_WEIGHT(RW), .OFFSET(OFF)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_v2c(v2c), .i_v2c_valid(v2c_valid), .o_v2c_ready(v2c_ready),
    .o_c2v(c2v), .o_c2v_valid(c2v_valid), .i_c2v_ready(c2v_ready),
    .o_c2v_last(c2v_last), .o_sign_prod(sign_prod)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: scoreboard pop on every consumed beat, hold check while stalled
  always @(negedge clk) begin
    logic [MW+1:0] obs;
    logic [MW+1:0] exp_w;
    obs = {c2v_last, sign_prod, c2v};
    if (!rst && c2v_valid) begin
      if (stall_prev) begin
        n_cmp++;
        if (obs !== held) begin
          n_bad++;
          $display("FAIL hold_stable: got %b want %b", obs, held);
        end
      end
      if (c2v_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: got %b with empty scoreboard", obs);
        end else begin
          exp_w = sb.pop_front();
          if (obs !== exp_w) begin
            n_bad++;
            $display("FAIL c2v_beat: got last/sp/c2v %b want %b", obs, exp_w);
          end
        end
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        held = obs;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: each c2v is the min and sign product over all other beats of the row
  function automatic void push_row(input mag_arr_t m, input logic [RW-1:0] s);
    for (int k = 0; k < RW; k++) begin
      int mn = 31;
      int mg;
      logic sg = 1'b0;
      for (int j = 0; j < RW; j++) begin
        if (j != k) begin
          if (int'(m[j]) < mn) mn = int'(m[j]);
          sg ^= s[j];
        end
      end
      mg = (mn > OFF) ? mn - OFF : 0;
      if (mg == 0) sg = 1'b0;
      sb.push_back({(k == RW - 1), ^s, sg, 5'(mg)});
    end
  endfunction

  task automatic send_beats(input mag_arr_t m, input logic [RW-1:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      v2c = {s[k], m[k]};
      v2c_valid = 1'b1;
      while (!v2c_ready && t < 300) begin
        step();
        t++;
      end
      if (!v2c_ready) begin
        n_cmp++;
        n_bad++;
        $display("FAIL v2c_ready_timeout: beat %0d got ready=0 want 1", k);
      end
      step();
    end
    v2c_valid = 1'b0;
  endtask

  task automatic send_row(input mag_arr_t m, input logic [RW-1:0] s);
    push_row(m, s);
    send_beats(m, s, RW);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || c2v_valid) && t < 500) begin
      step();
      t++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d beats pending want 0", sb.size());
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if ({v2c_ready, c2v_valid, c2v_last, sign_prod, c2v} !== '0) begin
      n_bad++;
      $display("FAIL %s: got rdy/vld/last/sp/c2v %b want all zero", tag,
               {v2c_ready, c2v_valid, c2v_last, sign_prod, c2v});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset_outputs");
    rst = 1'b0;
    #1;
    n_cmp++;
    if (v2c_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b want 1", v2c_ready);
    end
  endtask

  task automatic test_patterns();
    mag_arr_t m;
    m = '{5, 3, 9, 3, 7, 12};
    send_row(m, 6'b010010);
    m = '{1, 20, 20, 20, 20, 20};
    send_row(m, 6'b000100);
    m = '{31, 31, 31, 31, 31, 31};
    send_row(m, 6'b111111);
    wait_drain();
  endtask

  task automatic test_latency();
    mag_arr_t m;
    m = '{5, 3, 9, 3, 7, 12};
    send_row(m, 6'b010010);
    n_cmp++;
    if (c2v_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_t1: got valid=%b want 0", c2v_valid);
    end
    step();
    n_cmp++;
    if (c2v_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_t2: got valid=%b want 1", c2v_valid);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    mag_arr_t m;
    int t_end [3];
    c2v_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < RW; k++) m[k] = 5'(2 + r * 3 + k * 4);
      send_row(m, 6'(r * 21 + 5));
      t_end[r] = cyc;
    end
    for (int r = 1; r < 3; r++) begin
      n_cmp++;
      if (t_end[r] - t_end[r-1] != 7) begin
        n_bad++;
        $display("FAIL row_period: got %0d cycles want 7", t_end[r] - t_end[r-1]);
      end
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    mag_arr_t m;
    int t = 0;
    int c0;
    m = '{5, 3, 9, 3, 7, 12};
    send_row(m, 6'b010010);
    while (!c2v_valid && t < 50) begin
      step();
      t++;
    end
    step();
    step();
    c2v_ready = 1'b0;
    c0 = cyc;
    m = '{17, 4, 22, 0, 9, 4};
    send_row(m, 6'b101100);
    n_cmp++;
    if (v2c_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_stall: got v2c_ready=%b want 0", v2c_ready);
    end
    n_cmp++;
    if (c2v_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_valid: got c2v_valid=%b want 1", c2v_valid);
    end
    while (cyc - c0 < 10) step();
    c2v_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid_row();
    mag_arr_t m;
    m = '{0, 2, 0, 30, 1, 1};
    send_beats(m, 6'b111111, 3);
    rst = 1'b1;
    step();
    check_idle_outputs("reset_mid_row");
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (v2c_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_mid_reset: got %b want 1", v2c_ready);
    end
    m = '{5, 3, 9, 3, 7, 12};
    send_row(m, 6'b010010);
    wait_drain();
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        mag_arr_t m;
        logic [RW-1:0] s;
        for (int r = 0; r < 6; r++) begin
          for (int k = 0; k < RW; k++) m[k] = 5'($urandom_range(0, 31));
          s = RW'($urandom_range(0, 63));
          send_row(m, s);
        end
        done = 1'b1;
      end
      begin
        int t = 0;
        while (!done && t < 2000) begin
          c2v_ready = ($urandom_range(0, 3) != 0);
          step();
          t++;
        end
      end
    join
    c2v_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_row();
    test_random();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
